// File: rtl/seg_scan_4dig.sv
// Four-digit multiplexed 7-segment scanner fed by a 4-deep nibble shift buffer.
// Optional macro SEG_SCAN_LEAD_BLANK_EN blanks digit positions above the fill count.
module seg_scan_4dig #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] data,
  input  logic       valid,
  output logic       ready,
  input  logic       clr,
  output logic [6:0] ss,
  output logic [3:0] dig
);

  localparam logic [15:0] PC_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SS_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]  DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [3:0]  d_q [4];   // d_q[0] is D1 (rightmost)
  logic [3:0]  d_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  idx_q, idx_d; // 0..3 encodes digit 1..4
  logic [6:0]  ss_q, ss_d;
  logic [3:0]  dig_q, dig_d;
  logic [6:0]  seg_raw;
  logic [3:0]  dig_raw;
  logic        xfer;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  assign ready = RSTn & ~clr;
  assign xfer  = valid & ready;

  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    if (clr) begin
      for (int i = 0; i < 4; i++) d_d[i] = 4'h0;
      cnt_d = 3'd0;
    end else if (xfer) begin
      d_d[3] = d_q[2];
      d_d[2] = d_q[1];
      d_d[1] = d_q[0];
      d_d[0] = data;
      if (cnt_q != 3'd4) cnt_d = cnt_q + 3'd1;
    end
  end

  always_comb begin
    pc_d  = pc_q + 16'd1;
    idx_d = idx_q;
    if (pc_q == PC_LAST) begin
      pc_d  = 16'd0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Slot output computed from current state; pc==0 is the anti-ghosting dead cycle.
  always_comb begin
    seg_raw = hex_to_seg(d_q[idx_q]);
`ifdef SEG_SCAN_LEAD_BLANK_EN
    if (({1'b0, idx_q} + 3'd1) > cnt_q) seg_raw = 7'h00;
`endif
    dig_raw = 4'b0001 << idx_q;
    if (pc_q == 16'd0) begin
      seg_raw = 7'h00;
      dig_raw = 4'h0;
    end
    ss_d  = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_d = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < 4; i++) d_q[i] <= 4'h0;
      cnt_q <= 3'd0;
      pc_q  <= 16'd0;
      idx_q <= 2'd0;
      ss_q  <= SS_OFF;
      dig_q <= DIG_OFF;
    end else begin
      d_q   <= d_d;
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
      idx_q <= idx_d;
      ss_q  <= ss_d;
      dig_q <= dig_d;
    end
  end

  assign ss  = ss_q;
  assign dig = dig_q;

endmodule

// File: doc/seg_scan_4dig.md
SEG_SCAN_4DIG -- requirements
Module: seg_scan_4dig

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal 2..65535).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1, 1 = segment lit when its ss bit is 0.
REQ-003 SHALL have parameter DIG_ACTIVE_LOW, default 1, 1 = digit enabled when its dig bit is 0.
REQ-004 CLK  input  1  sole clock, all logic on rising edge.
REQ-005 RSTn  input  1  reset, synchronous, active-low.
REQ-006 data  input  4  hex nibble offered by the upstream FIFO read side.
REQ-007 valid  input  1  data is valid this cycle.
REQ-008 ready  output  1  block accepts data this cycle; transfer = valid && ready.
REQ-009 clr  input  1  synchronous display clear request.
REQ-010 ss  output  7  segments {g,f,e,d,c,b,a}, registered.
REQ-011 dig  output  4  digit enables dig[4:1], dig[1] rightmost, registered.

Function
REQ-012 Buffer SHALL hold four nibbles D4..D1 plus a fill count cnt (0..4).
REQ-013 ready SHALL equal !clr whenever RSTn is high; it SHALL be 0 while RSTn is low.
REQ-014 On transfer: D4<=D3, D3<=D2, D2<=D1, D1<=data, and cnt<=min(cnt+1,4). Old D4 is discarded; there is no backpressure when the buffer is full.
REQ-015 clr=1 SHALL set D4..D1=0 and cnt=0 on the next edge. No transfer occurs that cycle, even if valid=1.
REQ-016 Prescaler pc SHALL count 0..SCAN_DIV-1 and wrap to 0. Digit index idx (1..4) SHALL advance 1->2->3->4->1 on the edge where pc wraps.
REQ-017 Dead time: when pc==0, the registered outputs (visible next cycle) SHALL be all digits disabled and all segments off, to prevent ghosting.
REQ-018 When pc!=0, the next-cycle outputs SHALL enable only digit idx and drive the hex decode of D[idx].
REQ-019 Hex decode, standard 7-seg, active-high form {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-020 Polarity SHALL be applied after decode. ss is inverted when SEG_ACTIVE_LOW=1; dig is inverted when DIG_ACTIVE_LOW=1.
REQ-021 Output latency SHALL be 1 cycle from the (pc, idx, D) state to ss/dig.
REQ-022 A buffer write SHALL become visible at the next slot computation. No tearing: ss and dig SHALL always come from the same registered update.
REQ-023 Prescaler and idx SHALL be unaffected by transfer and clr.

Reset
REQ-024 With RSTn=0 at an edge: D4..D1=0, cnt=0, pc=0, idx=1, all digits disabled, all segments off (after polarity).
REQ-025 Reset asserted mid-slot or mid-transfer SHALL abort the slot. The first cycle after release is a dead-time cycle (pc=0).

Configuration
REQ-026 Macro SEG_SCAN_LEAD_BLANK_EN defined: a digit position k>cnt SHALL show all segments off while its dig stays enabled (blank leading digits). With cnt=0, all four are blank.
REQ-027 Macro undefined: cnt SHALL still be maintained, and all four positions SHALL show decode of D[k] (leading zeros visible).

Verification
REQ-028 SCAN_DIV=4, both polarities 1, reset then idle 20 cycles -> dig cycles 1110,1101,1011,0111 with one 1111 dead cycle per slot; ss=1000000 ("0") when macro undefined.
REQ-029 Push 1,2,3,4 back-to-back with valid=1 -> ready=1 all four cycles; slots show dig[4]="1", dig[3]="2", dig[2]="3", dig[1]="4" (ss 1111001, 0100100, 0110000, 0011001).
REQ-030 Push 5 after REQ-029 -> display "2345"; cnt stays 4; ready stays 1.
REQ-031 valid=1, data=7, clr=1 same cycle -> ready=0, no write; buffer all 0, cnt=0 next cycle.
REQ-032 Macro defined, push A only -> dig[1] slot ss=0001000; dig[4..2] slots ss=1111111 with their dig enabled.
REQ-033 RSTn low for 1 cycle in the middle of a dig[3] slot -> next cycle outputs 1111/1111111; then a dig[1] slot follows after one dead cycle.
